// File: rtl/readout_sequencer.sv
// Readout sequencer: walks NUM_WORDS buffer addresses and streams each word.
// Optional out_parity output enabled by READOUT_SEQ_PARITY_EN.
module readout_sequencer #(
    parameter int N         = 8,
    parameter int ADDR_W    = 6,
    parameter int NUM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              src_sel,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              buf_src,
    output logic              buf_en,
    input  logic [N-1:0]      buf_value,
    output logic [N-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef READOUT_SEQ_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LOAD,
        SEND,
        FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic              src_q, src_d;
    logic [ADDR_W-1:0] addr_d;
    logic              buf_src_d;
    logic              buf_en_d;
    logic [N-1:0]      out_data_d;
    logic              out_valid_d;
    logic              out_last_d;
    logic              busy_d;
    logic              done_d;
`ifdef READOUT_SEQ_PARITY_EN
    logic              parity_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= 1'b0;
            addr       <= '0;
            buf_src    <= 1'b0;
            buf_en     <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef READOUT_SEQ_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            addr       <= addr_d;
            buf_src    <= buf_src_d;
            buf_en     <= buf_en_d;
            out_data   <= out_data_d;
            out_valid  <= out_valid_d;
            out_last   <= out_last_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef READOUT_SEQ_PARITY_EN
            out_parity <= parity_d;
`endif
        end
    end

    // Outputs are registered, so each is computed from the upcoming state.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        addr_d      = addr;
        buf_src_d   = buf_src;
        buf_en_d    = 1'b0;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        done_d      = 1'b0;
`ifdef READOUT_SEQ_PARITY_EN
        parity_d    = out_parity;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d     = src_sel;
                    buf_src_d = src_sel;
                    addr_d    = '0;
                    buf_en_d  = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = LOAD;
            end
            LOAD: begin
                out_data_d  = buf_value;
                out_valid_d = 1'b1;
                out_last_d  = (addr == LAST_ADDR);
`ifdef READOUT_SEQ_PARITY_EN
                parity_d    = ^buf_value;
`endif
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last) begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        addr_d    = addr + ADDR_W'(1);
                        buf_en_d  = 1'b1;
                        buf_src_d = src_q;
                        state_d   = ISSUE;
                    end
                end
            end
            FINISH: begin
                addr_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort overrides any handshake taken in the same cycle.
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            addr_d      = '0;
            buf_en_d    = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer (NUM_WORDS=4 plus a NUM_WORDS=1 unit).
module tb_readout_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       src_sel;
    logic       abort;
    logic       out_ready;
    logic [5:0] addr, addr1;
    logic       buf_src, buf_src1;
    logic       buf_en, buf_en1;
    logic [7:0] buf_value, buf_value1;
    logic [7:0] out_data, out_data1;
    logic       out_valid, out_valid1;
    logic       out_last, out_last1;
    logic       busy, busy1;
    logic       done, done1;
`ifdef READOUT_SEQ_PARITY_EN
    logic       out_parity, out_parity1;
`endif
    logic [7:0] base;
    int         passed = 0;
    int         failed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    readout_sequencer #(.N(8), .ADDR_W(6), .NUM_WORDS(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .src_sel(src_sel),
        .abort(abort), .addr(addr), .buf_src(buf_src), .buf_en(buf_en),
        .buf_value(buf_value), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
`ifdef READOUT_SEQ_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    readout_sequencer #(.N(8), .ADDR_W(6), .NUM_WORDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .src_sel(src_sel),
        .abort(abort), .addr(addr1), .buf_src(buf_src1), .buf_en(buf_en1),
        .buf_value(buf_value1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_last(out_last1), .busy(busy1), .done(done1)
`ifdef READOUT_SEQ_PARITY_EN
        , .out_parity(out_parity1)
`endif
    );

    // Buffer model: word is valid only the cycle after buf_en.
    always @(posedge clk) begin
        buf_value  <= buf_en ? base + {2'b00, addr} : 8'hEE;
        buf_value1 <= buf_en1 ? 8'hA0 : 8'hEE;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic word(input int i, input logic src, input int stall,
                        input bit last, input bit c1);
        logic [7:0] w;
        logic [5:0] a;
        w = base + 8'(i);
        a = 6'(i);
        chk("issue_en", buf_en, 1);
        chk("issue_src", buf_src, src);
        chk("issue_addr", addr, a);
        chk("issue_valid", out_valid, 0);
        if (stall > 0) out_ready = 1'b0;
        tick;
        chk("load_en", buf_en, 0);
        chk("load_valid", out_valid, 0);
        tick;
        chk("send_valid", out_valid, 1);
        chk("send_data", out_data, w);
        chk("send_last", out_last, last);
`ifdef READOUT_SEQ_PARITY_EN
        chk("send_parity", out_parity, ^w);
`endif
        if (c1) begin
            chk("u1_valid", out_valid1, 1);
            chk("u1_last", out_last1, 1);
            chk("u1_data", out_data1, 8'hA0);
        end
        for (int k = 0; k < stall; k++) begin
            tick;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, w);
            chk("hold_en", buf_en, 0);
        end
        out_ready = 1'b1;
        tick;
        chk("post_valid", out_valid, 0);
        chk("post_last", out_last, 0);
        chk("done", done, last);
        if (c1) chk("u1_done", done1, 1);
    endtask

    task automatic frame(input logic src, input logic [7:0] b,
                         input int stall_word, input bit c1);
        base    = b;
        src_sel = src;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        src_sel = ~src;
        chk("frame_busy", busy, 1);
        for (int i = 0; i < 4; i++)
            word(i, src, (i == stall_word) ? 5 : 0, i == 3, c1 && i == 0);
        chk("finish_busy", busy, 1);
        tick;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_addr", addr, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        src_sel   = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        base      = 8'h10;
        #12;
        chk("rst_addr", addr, 0);
        chk("rst_en", buf_en, 0);
        chk("rst_src", buf_src, 0);
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick;

        frame(1'b1, 8'h10, -1, 1'b1);
        frame(1'b1, 8'h10, 2, 1'b0);

        base    = 8'hB5;
        src_sel = 1'b1;
        start   = 1'b1;
        abort   = 1'b1;
        tick;
        start   = 1'b0;
        abort   = 1'b0;
        chk("sa_busy", busy, 1);
        word(0, 1'b1, 0, 1'b0, 1'b0);
        tick;
        tick;
        chk("ab_send", out_valid, 1);
        abort     = 1'b1;
        out_ready = 1'b0;
        tick;
        abort     = 1'b0;
        out_ready = 1'b1;
        chk("ab_valid", out_valid, 0);
        chk("ab_busy", busy, 0);
        chk("ab_en", buf_en, 0);
        chk("ab_last", out_last, 0);
        chk("ab_done", done, 0);
        tick;
        chk("ab_done2", done, 0);
        chk("ab_idle", busy, 0);

        base  = 8'h20;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        chk("mr_addr", addr, 0);
        chk("mr_src", buf_src, 0);
        chk("mr_en", buf_en, 0);
        chk("mr_data", out_data, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("mr_idle1", busy, 0);
        tick;
        chk("mr_idle2", busy, 0);
        chk("mr_noen", buf_en, 0);
        chk("mr_nodone", done, 0);

        frame(1'b0, 8'h33, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Initiator/consumer side of the pixel/memory readout buffer interface.
- On `start`, walks `NUM_WORDS` consecutive addresses. For each address it drives the buffer's source select and enable, then captures the buffered word one cycle later.
- Emits each captured word on a valid/ready stream toward the serial link / host FIFO.
- Sits between the frame control logic and the readout buffer plus its downstream packetiser.

Parameters:
- `N`, 8: word width, matches the buffer data width.
- `ADDR_W`, 6: width of the word address presented to the pixel array / memory.
- `NUM_WORDS`, 64: words per frame. Must satisfy 1 <= `NUM_WORDS` <= 2^`ADDR_W`.

Ports:
- `clk`  input  1  clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request to begin a frame readout; sampled only in IDLE.
- `src_sel`  input  1  source for the frame: 0 = memory, 1 = pixel; latched on accepted `start`.
- `abort`  input  1  synchronous abort of the current frame.
- `addr`  output  `ADDR_W`  current word address to pixel array / memory.
- `buf_src`  output  1  source select to readout buffer.
- `buf_en`  output  1  one-cycle load enable to readout buffer.
- `buf_value`  input  N  registered buffer output; valid the cycle after `buf_en`.
- `out_data`  output  N  stream data.
- `out_valid`  output  1  stream valid.
- `out_ready`  input  1  stream ready from consumer.
- `out_last`  output  1  marks final word of frame; qualified by `out_valid`.
- `busy`  output  1  high whenever state is not IDLE.
- `done`  output  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (async, `rst_n`=0) forces:
  - state = IDLE
  - `addr`=0, `buf_src`=0, `buf_en`=0
  - `out_data`=0, `out_valid`=0, `out_last`=0
  - `busy`=0, `done`=0
  - internal latched `src_sel`=0
- Reset mid-frame discards the frame; no `done` is issued.
- All outputs are registered.
- FSM states: IDLE, ISSUE, LOAD, SEND, FINISH.
- IDLE:
  - `start`=1 latches `src_sel`, sets `addr`=0 and goes to ISSUE.
  - `start` in any other state is ignored.
- ISSUE:
  - `buf_en`=1 for exactly this cycle, with `buf_src` = latched `src_sel` and `addr` stable.
  - Next state LOAD.
- LOAD:
  - `buf_value` is valid this cycle; capture it into `out_data`.
  - Set `out_valid`=1, and set `out_last`=1 iff `addr` == `NUM_WORDS`-1.
  - Next state SEND.
- SEND:
  - Hold `out_data`, `out_valid` and `out_last` stable until `out_valid` && `out_ready`.
  - On that handshake, drop `out_valid` next cycle.
  - If it was the last word, go to FINISH; otherwise `addr` <= `addr`+1 and go to ISSUE.
- FINISH:
  - `done`=1 for one cycle, `addr` returns to 0, next state IDLE.
  - `busy` falls in the same cycle `done` is observed low again, i.e. `busy`=0 from IDLE onward.
- Throughput:
  - Minimum 3 cycles per word with `out_ready` held high.
  - First `out_valid` appears 3 cycles after the `start` edge: IDLE->ISSUE->LOAD->SEND, with `out_valid` visible in SEND.
- Address arithmetic:
  - Increment is modulo 2^`ADDR_W`. Wrap cannot occur given the `NUM_WORDS` constraint.
  - `NUM_WORDS`=1: the first word carries `out_last`=1.
- Abort:
  - `abort`=1 in any non-IDLE state goes to IDLE next cycle.
  - Clears `out_valid`, `out_last` and `buf_en`; no `done` pulse.
  - `abort` in IDLE has no effect.
  - `abort` and a handshake on the same cycle: abort wins, and the word counts as delivered.
- Simultaneous `start`+`abort` in IDLE: `start` is accepted and `abort` is ignored.
- `buf_value` is ignored outside LOAD.

Optional Feature:
- Macro: `READOUT_SEQ_PARITY_EN`.
- When defined:
  - Adds output `out_parity` (1 bit): even parity (XOR reduction) of the captured word.
  - Registered in LOAD alongside `out_data` and held through SEND. Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame: `NUM_WORDS`=4, `src_sel`=1, buffer model returns `addr`+8'h10, `out_ready`=1 -> stream 8'h10,8'h11,8'h12,8'h13; `out_last` only on 8'h13; `done` pulses once, 1 cycle after last handshake; `buf_src`=1 on every `buf_en`.
- Backpressure: `out_ready`=0 for 5 cycles on word 2 -> `out_data`/`out_valid` held stable; no extra `buf_en` pulse; sequence unchanged.
- Source latch: `start` with `src_sel`=0, then toggle `src_sel` mid-frame -> all `buf_en` cycles show `buf_src`=0.
- Abort: assert `abort` during SEND of word 1 -> `out_valid`=0 and `busy`=0 next cycle; no `done`; a new `start` then begins at `addr`=0.
- Reset mid-frame: drop `rst_n` during LOAD -> all outputs 0 immediately (async); after release, `start` ignored while `busy`=0 until issued again.
- Parity (macro defined): captured value 8'hB5 -> `out_parity`=1; 8'h33 -> `out_parity`=0.
